// File: rtl/if_stage_pkg.sv
// Shared constants for the instruction-fetch stage and its neighbours
// (InstMem enable levels, bus widths, reset PC and NOP encoding).
package if_stage_pkg;

    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_W      = 32;

    localparam logic ROM_ENABLE  = 1'b1;
    localparam logic ROM_DISABLE = 1'b0;

    localparam logic [INST_ADDR_W-1:0] ZERO_ADDR = 32'h0000_0000;
    localparam logic [INST_ADDR_W-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [INST_W-1:0]      NOP_INST  = 32'h0000_0000;

    // Instruction fetches are word aligned; low address bits are dropped silently.
    function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] addr);
        return {addr[INST_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter with InstMem enable generation and prioritised next-PC
// selection (reset-hold, CP0 flush, stall, branch redirect, sequential).
module if_stage_pc_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC_P = RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] pc_o,
    output logic        ce_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        ce_q;

    // Next-PC mux: while InstMem is still disabled the PC parks at the reset vector.
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (ce_q == ROM_DISABLE) begin
            pc_d = RESET_PC_P;
        end else if (flush_i) begin
            pc_d = word_align(flush_pc_i);
        end else if (stall_i) begin
            pc_d = pc_q;
        end else if (branch_taken_i) begin
            pc_d = word_align(branch_target_i);
        end else begin
            pc_d = pc_q + 32'd4;
        end
    end

    // PC and fetch-enable state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC_P;
            ce_q <= ROM_DISABLE;
        end else begin
            pc_q <= pc_d;
            ce_q <= ROM_ENABLE;
        end
    end

    assign pc_o = pc_q;
    assign ce_o = ce_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: drives InstMem from the PC and captures the returned
// word into the IF/ID pipeline register, honouring stall and flush.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC_P = RESET_PC,
    parameter logic [31:0] NOP_INST_P = NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid
);

    logic [31:0] pc_s;
    logic        ce_s;

    logic [31:0] id_pc_q;
    logic [31:0] id_pc_d;
    logic [31:0] id_inst_q;
    logic [31:0] id_inst_d;
    logic        id_valid_q;
    logic        id_valid_d;

    if_stage_pc_reg #(
        .RESET_PC_P(RESET_PC_P)
    ) u_pc_reg (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall),
        .flush_i        (flush),
        .flush_pc_i     (flush_pc),
        .branch_taken_i (branch_taken),
        .branch_target_i(branch_target),
        .pc_o           (pc_s),
        .ce_o           (ce_s)
    );

    // IF/ID next state: flush preempts stall; a fetch while disabled becomes a bubble.
    always_comb begin
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        if (flush) begin
            id_pc_d    = ZERO_ADDR;
            id_inst_d  = NOP_INST_P;
            id_valid_d = 1'b0;
        end else if (stall) begin
            id_pc_d    = id_pc_q;
            id_inst_d  = id_inst_q;
            id_valid_d = id_valid_q;
        end else begin
            id_pc_d    = pc_s;
            id_inst_d  = rom_data;
            id_valid_d = ce_s;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_pc_q    <= ZERO_ADDR;
            id_inst_q  <= NOP_INST_P;
            id_valid_q <= 1'b0;
        end else begin
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign rom_ce   = ce_s;
    assign rom_addr = pc_s;
    assign id_pc    = id_pc_q;
    assign id_inst  = id_inst_q;
    assign id_valid = id_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a combinational InstMem model whose word
// at address A is 0xA500_0000 | A (zero while the ROM is disabled).
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;

    int total = 0;
    int bad   = 0;

    if_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .rom_ce       (rom_ce),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .id_pc        (id_pc),
        .id_inst      (id_inst),
        .id_valid     (id_valid)
    );

    assign rom_data = rom_ce ? (32'hA500_0000 | rom_addr) : 32'h0000_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; flush_pc = 32'h0;
        branch_taken = 1'b0; branch_target = 32'h0;
        #3;
        chk("rst_ce",    {31'd0, rom_ce},   32'h0);
        chk("rst_addr",  rom_addr,          32'h0);
        chk("rst_idpc",  id_pc,             32'h0);
        chk("rst_inst",  id_inst,           32'h0);
        chk("rst_valid", {31'd0, id_valid}, 32'h0);

        // Reset release
        @(negedge clk); rst = 1'b0;
        step();
        chk("c1_ce",    {31'd0, rom_ce},   32'h1);
        chk("c1_addr",  rom_addr,          32'h0);
        chk("c1_valid", {31'd0, id_valid}, 32'h0);
        step();
        chk("c2_addr",  rom_addr,          32'h4);
        chk("c2_idpc",  id_pc,             32'h0);
        chk("c2_inst",  id_inst,           32'hA500_0000);
        chk("c2_valid", {31'd0, id_valid}, 32'h1);
        step();
        chk("c3_addr",  rom_addr,          32'h8);
        chk("c3_idpc",  id_pc,             32'h4);
        step();
        step();
        chk("c5_addr",  rom_addr,          32'h10);
        chk("c5_inst",  id_inst,           32'hA500_000C);

        // Two-cycle stall at pc=0x10
        stall = 1'b1;
        step();
        chk("st1_addr", rom_addr, 32'h10);
        chk("st1_idpc", id_pc,    32'hC);
        step();
        chk("st2_addr", rom_addr, 32'h10);
        chk("st2_idpc", id_pc,    32'hC);
        chk("st2_inst", id_inst,  32'hA500_000C);
        stall = 1'b0;
        step();
        chk("st3_addr", rom_addr, 32'h14);
        chk("st3_idpc", id_pc,    32'h10);
        step();
        step();
        chk("pre_br_addr", rom_addr, 32'h1C);

        // Branch with delay slot
        branch_taken = 1'b1; branch_target = 32'h30;
        step();
        branch_taken = 1'b0;
        chk("br_addr",  rom_addr,          32'h30);
        chk("br_idpc",  id_pc,             32'h1C);
        chk("br_inst",  id_inst,           32'hA500_001C);
        chk("br_valid", {31'd0, id_valid}, 32'h1);
        step();
        chk("br2_addr", rom_addr, 32'h34);
        chk("br2_inst", id_inst,  32'hA500_0030);
        branch_taken = 1'b1; branch_target = 32'h33;
        step();
        branch_taken = 1'b0;
        chk("bral_addr", rom_addr, 32'h30);
        chk("bral_idpc", id_pc,    32'h34);
        step();
        chk("bral2_addr", rom_addr, 32'h34);

        // Branch during stall is ignored until stall drops
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h100;
        step();
        chk("brst_addr", rom_addr, 32'h34);
        chk("brst_idpc", id_pc,    32'h30);
        stall = 1'b0;
        step();
        branch_taken = 1'b0;
        chk("brst2_addr", rom_addr, 32'h100);
        chk("brst2_idpc", id_pc,    32'h34);

        // Flush beats stall and branch; low target bits dropped
        flush = 1'b1; flush_pc = 32'h0000_0E1A;
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h200;
        step();
        flush = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        chk("fl_addr",  rom_addr,          32'hE18);
        chk("fl_inst",  id_inst,           32'h0);
        chk("fl_idpc",  id_pc,             32'h0);
        chk("fl_valid", {31'd0, id_valid}, 32'h0);
        step();
        chk("fl2_addr",  rom_addr,          32'hE1C);
        chk("fl2_idpc",  id_pc,             32'hE18);
        chk("fl2_inst",  id_inst,           32'hA500_0E18);
        chk("fl2_valid", {31'd0, id_valid}, 32'h1);

        // PC wrap-around
        flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
        step();
        flush = 1'b0;
        chk("wr_addr", rom_addr, 32'hFFFF_FFFC);
        step();
        chk("wr2_addr",  rom_addr,          32'h0);
        chk("wr2_idpc",  id_pc,             32'hFFFF_FFFC);
        chk("wr2_inst",  id_inst,           32'hFFFF_FFFC);
        chk("wr2_valid", {31'd0, id_valid}, 32'h1);
        step();
        chk("wr3_addr", rom_addr, 32'h4);
        chk("wr3_idpc", id_pc,    32'h0);

        // Asynchronous reset between edges
        #2; rst = 1'b1;
        #1;
        chk("ar_ce",    {31'd0, rom_ce},   32'h0);
        chk("ar_addr",  rom_addr,          32'h0);
        chk("ar_idpc",  id_pc,             32'h0);
        chk("ar_inst",  id_inst,           32'h0);
        chk("ar_valid", {31'd0, id_valid}, 32'h0);
        step();
        chk("ar_hold_ce", {31'd0, rom_ce}, 32'h0);
        @(negedge clk); rst = 1'b0;
        step();
        chk("ar1_ce",    {31'd0, rom_ce},   32'h1);
        chk("ar1_addr",  rom_addr,          32'h0);
        chk("ar1_valid", {31'd0, id_valid}, 32'h0);
        step();
        chk("ar2_addr",  rom_addr,          32'h4);
        chk("ar2_inst",  id_inst,           32'hA500_0000);
        chk("ar2_valid", {31'd0, id_valid}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
